ysyx_23060201_if_id_buf: RTL and testbench
==========================================

# ysyx_23060201_if_id_buf

Pipeline buffer between the instruction fetch stage and the decode stage of the ysyx_23060201 core. It captures each fetched `{pc, inst}` pair under a valid/ready handshake and presents it to the decoder one cycle later. It decouples fetch from decode back-pressure and discards wrong-path instructions when the execute stage redirects the PC. An optional second (skid) entry registers `in_ready` so that no combinational ready path runs from decode back into fetch.

## Interface
- `ADDR_WIDTH`, 32, PC width.
- `DATA_WIDTH`, 32, instruction width.
- `RESET_PC`, 32'h8000_0000, reset value of `out_pc` (equals `MBASE`).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  redirect/kill: drop all buffered and incoming entries.
- `in_valid`  in  1  fetch stage offers `in_pc`/`in_inst`.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_pc`  in  ADDR_WIDTH  PC of fetched instruction.
- `in_inst`  in  DATA_WIDTH  fetched instruction word.
- `out_valid`  out  1  entry available to decode.
- `out_ready`  in  1  decode consumes this cycle.
- `out_pc`  out  ADDR_WIDTH  PC of head entry.
- `out_inst`  out  DATA_WIDTH  instruction of head entry.
- `count`  out  2  number of valid entries (0..2; max 1 without skid).

## Operation
- Accept: `in_valid && in_ready` at an edge. Release: `out_valid && out_ready` at an edge.
- Storage: main entry M drives `out_*`. Skid entry S exists only with `IFID_SKID_EN`.
- `out_valid = M.valid && !flush`. `out_pc`/`out_inst` always reflect M's fields, even when M is invalid.
- Order is strictly FIFO. No reordering or duplication is allowed.
- Next state when `!flush`:
  - M empty, or M released: M <= S if S valid, else M <= input if accepted, else M becomes invalid.
  - M held (valid, not released) and input accepted: input goes to S.
  - M released with S valid: M <= S and S is cleared. No accept can happen in this cycle, because `in_ready = 0` while S is valid.
- Flush: at the edge, M and S are invalidated. An input handshake in the same cycle completes, but its data is discarded. Fields keep their old values and only the valid bits clear.
- Flush has priority over accept and release. Because `out_valid` is masked, no release happens in a flush cycle.
- `inst == 0` is passed through unmodified; decode handles it.
- `count` = M.valid + S.valid, registered.

## Timing
- Reset (sync, at the edge with `rst = 1`):
  - M.valid = 0 and S.valid = 0, so `out_valid = 0` and `count = 0`.
  - `out_pc = RESET_PC`, `out_inst = 0`.
  - `in_ready = 1` from the first cycle after reset.
- Reset asserted mid-operation drops all entries exactly like a flush and overrides `flush` and both handshakes.
- Latency: accept at edge N gives `out_valid = 1` in cycle N+1 with the accepted data.
- Throughput: 1 entry/cycle sustained while `out_ready = 1`.
- With `IFID_SKID_EN`: `in_ready = !S.valid`, a pure register output.
- Without: `in_ready = !M.valid || out_ready`, combinational from `out_ready`.
- `flush` affects `out_valid` combinationally in the same cycle. All other outputs are registered.

## Configuration
- `IFID_SKID_EN` defined:
  - Two-entry skid buffer.
  - `in_ready` is registered; at most one accepted-but-blocked entry sits in S.
  - `count` can reach 2.
- Not defined:
  - Single-entry pipeline register; S and its logic are absent.
  - `in_ready` depends combinationally on `out_ready`.
  - `count` ≤ 1.
- Handshake semantics, flush behaviour and latency are identical in both builds.

## Test plan
- Reset:
  - Stimulus: hold `rst = 1` for 2 cycles with `in_valid = 1`, `in_pc = 0x80000000`.
  - Required: `out_valid = 0`, `out_pc = 0x80000000`, `out_inst = 0`, `count = 0`.
  - After release, `in_ready = 1`.
- Streaming:
  - Stimulus: `out_ready = 1`; offer pc 0x80000000/0x80000004/0x80000008 with insts 0x00000413/0x00100493/0x00940433 on consecutive cycles.
  - Required: each appears on `out_*` exactly one cycle after it is accepted, with no gaps.
- Back-pressure (skid build):
  - Stimulus: drop `out_ready` with M holding 0x80000000, then offer 0x80000004.
  - Required: 0x80000004 is accepted into S; `count = 2`; `in_ready = 0` the next cycle.
  - Stimulus: raise `out_ready`.
  - Required: out order 0x80000000 then 0x80000004; `in_ready = 1` after S drains.
- Back-pressure (no-skid build):
  - Same stimulus.
  - Required: `in_ready = 0` in the cycle where `out_ready = 0` and M is valid; 0x80000004 is held by fetch.
- Flush:
  - Stimulus: M = 0x80000010 and S = 0x80000014 valid; assert `flush` with `in_valid = 1`, `in_pc = 0x80000018`.
  - Required: `out_valid = 0` in that cycle; `count = 0` next cycle; 0x80000018 is never output.
  - Stimulus: next offer 0x80000100.
  - Required: 0x80000100 is output one cycle later.
- Reset mid-stream:
  - Stimulus: assert `rst` while `count = 2` and `out_ready = 1`.
  - Required: no release that cycle; `count = 0` and `out_pc = 0x80000000` after the edge.

Source files
------------

// File: rtl/ysyx_23060201_if_id_buf.sv
// ysyx_23060201_if_id_buf: IF->ID pipeline buffer with valid/ready handshake and flush.
// Defining IFID_SKID_EN adds a skid entry so that in_ready becomes a pure register output.
module ysyx_23060201_if_id_buf #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [1:0]            count
);
   logic                  m_valid_q, m_valid_d;
   logic [ADDR_WIDTH-1:0] m_pc_q, m_pc_d;
   logic [DATA_WIDTH-1:0] m_inst_q, m_inst_d;
   logic                  s_valid, s_valid_d;
   logic [ADDR_WIDTH-1:0] s_pc;
   logic [DATA_WIDTH-1:0] s_inst;
   logic [1:0]            count_q, count_d;
   logic                  accept, rel, m_load;

   assign out_valid = m_valid_q && !flush;
   assign accept    = in_valid && in_ready;
   assign rel       = out_valid && out_ready;
   assign m_load    = !m_valid_q || rel;
   assign out_pc    = m_pc_q;
   assign out_inst  = m_inst_q;
   assign count     = count_q;

   // M refills from S first so the older entry always leaves before the incoming one
   always_comb begin
      m_valid_d = !flush && (m_load ? (s_valid || accept) : m_valid_q);
      m_pc_d    = (flush || !m_load) ? m_pc_q : s_valid ? s_pc : accept ? in_pc : m_pc_q;
      m_inst_d  = (flush || !m_load) ? m_inst_q : s_valid ? s_inst : accept ? in_inst : m_inst_q;
      count_d   = {1'b0, m_valid_d} + {1'b0, s_valid_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_pc_q    <= RESET_PC;
         m_inst_q  <= '0;
         count_q   <= 2'd0;
      end else begin
         m_valid_q <= m_valid_d;
         m_pc_q    <= m_pc_d;
         m_inst_q  <= m_inst_d;
         count_q   <= count_d;
      end
   end

`ifdef IFID_SKID_EN
   logic                  s_valid_q;
   logic [ADDR_WIDTH-1:0] s_pc_q, s_pc_d;
   logic [DATA_WIDTH-1:0] s_inst_q, s_inst_d;

   assign s_valid  = s_valid_q;
   assign s_pc     = s_pc_q;
   assign s_inst   = s_inst_q;
   assign in_ready = !s_valid_q;

   always_comb begin
      s_valid_d = !flush && !m_load && (s_valid_q || accept);
      s_pc_d    = (!flush && !m_load && accept) ? in_pc : s_pc_q;
      s_inst_d  = (!flush && !m_load && accept) ? in_inst : s_inst_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid_q <= 1'b0;
         s_pc_q    <= '0;
         s_inst_q  <= '0;
      end else begin
         s_valid_q <= s_valid_d;
         s_pc_q    <= s_pc_d;
         s_inst_q  <= s_inst_d;
      end
   end
`else
   assign s_valid   = 1'b0;
   assign s_valid_d = 1'b0;
   assign s_pc      = '0;
   assign s_inst    = '0;
   assign in_ready  = !m_valid_q || out_ready;
`endif
endmodule

// File: tb/tb_ysyx_23060201_if_id_buf.sv
// tb_ysyx_23060201_if_id_buf: directed bench with a queue model of the IF/ID buffer.
// Honours IFID_SKID_EN to select the two-entry model.
module tb_ysyx_23060201_if_id_buf;
`ifdef IFID_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [1:0]  count;
   int          checks = 0;
   int          fails = 0;
   bit          chk = 1'b0;
   logic [63:0] mq[$];
   logic [31:0] rel_log[$];
   logic [31:0] exp_log[6];

   ysyx_23060201_if_id_buf dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .count(count)
   );

   always #5 clk = ~clk;

   function automatic bit model_ready();
      return SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of {pc,inst}; capacity 2 with skid, else 1 with pass-through ready
   always @(posedge clk) begin
      automatic bit acc = in_valid && model_ready();
      automatic bit rls = mq.size() > 0 && !flush && out_ready;
      if (rst) chk <= 1'b1;
      if (rst || flush) mq.delete();
      else begin
         if (rls) void'(mq.pop_front());
         if (acc) mq.push_back({in_pc, in_inst});
      end
   end

   always @(negedge clk) begin
      if (chk) begin
         check("out_valid", 64'(out_valid), 64'(mq.size() > 0 && !flush));
         check("in_ready", 64'(in_ready), 64'(model_ready()));
         check("count", 64'(count), 64'(mq.size()));
         if (mq.size() > 0) check("head", {out_pc, out_inst}, mq[0]);
         if (out_valid && out_ready && !rst) rel_log.push_back(out_pc);
      end
   end

   task automatic set(input bit r, input bit f, input bit iv, input logic [31:0] pc,
                      input logic [31:0] ins, input bit ordy);
      rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = ins; out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      set(1, 0, 1, 32'h8000_0000, 32'h0000_0413, 0);
      tick(); tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'h8000_0000);
      check("rst_out_inst", 64'(out_inst), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      set(0, 0, 0, 32'h0, 32'h0, 1);
      #2 check("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      set(0, 0, 1, 32'h8000_0000, 32'h0000_0413, 1); tick();
      check("stream0", {out_valid, out_pc, out_inst}, {1'b1, 32'h8000_0000, 32'h0000_0413});
      set(0, 0, 1, 32'h8000_0004, 32'h0010_0493, 1); tick();
      check("stream1", {out_valid, out_pc, out_inst}, {1'b1, 32'h8000_0004, 32'h0010_0493});
      set(0, 0, 1, 32'h8000_0008, 32'h0094_0433, 1); tick();
      check("stream2", {out_valid, out_pc, out_inst}, {1'b1, 32'h8000_0008, 32'h0094_0433});
      set(0, 0, 0, 32'h0, 32'h0, 1); tick();
      check("stream_drain", 64'(count), 64'd0);
      set(0, 0, 1, 32'h8000_0000, 32'h0000_0413, 0); tick();
      set(0, 0, 1, 32'h8000_0004, 32'h0010_0493, 0); tick();
      check("bp_count", 64'(count), SKID ? 64'd2 : 64'd1);
      #2 check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      set(0, 0, 1, 32'h8000_0004, 32'h0010_0493, 1); tick();
      check("bp_head", {out_valid, out_pc}, {1'b1, 32'h8000_0004});
      set(0, 0, 0, 32'h0, 32'h0, 1); tick();
      check("bp_drained_ready", 64'(in_ready), 64'd1);
      check("bp_drained_count", 64'(count), 64'd0);
      set(0, 0, 1, 32'h8000_0010, 32'h1111_1111, 0); tick();
      set(0, 0, 1, 32'h8000_0014, 32'h2222_2222, 0); tick();
      check("fl_count_pre", 64'(count), SKID ? 64'd2 : 64'd1);
      set(0, 1, 1, 32'h8000_0018, 32'h3333_3333, 1);
      #2 check("fl_out_valid", 64'(out_valid), 64'd0);
      tick();
      check("fl_count_post", 64'(count), 64'd0);
      set(0, 0, 1, 32'h8000_0100, 32'h0000_0000, 1); tick();
      check("fl_next", {out_valid, out_pc, out_inst}, {1'b1, 32'h8000_0100, 32'h0});
      set(0, 0, 0, 32'h0, 32'h0, 1); tick();
      set(0, 0, 1, 32'h8000_0200, 32'h4444_4444, 0); tick();
      set(0, 0, 1, 32'h8000_0204, 32'h5555_5555, 0); tick();
      set(1, 0, 0, 32'h0, 32'h0, 1); tick();
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_pc", 64'(out_pc), 64'h8000_0000);
      set(0, 0, 0, 32'h0, 32'h0, 1); tick(); tick();
      exp_log = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008,
                  32'h8000_0000, 32'h8000_0004, 32'h8000_0100};
      check("release_count", 64'(rel_log.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("release_%0d", i), 64'(i < rel_log.size() ? rel_log[i] : 32'hdead_beef),
               64'(exp_log[i]));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
